// File: rtl/serial_alu_engine.sv
// Bit-serial ALU: add/sub/xor/slt computed one bit slice per clock, LSB first.
// Optional SERIAL_ALU_FLAGS_EN adds zero/carry_out/overflow result flags.
module serial_alu_engine #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
`ifdef SERIAL_ALU_FLAGS_EN
    ,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [1:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             bit_a, bit_b, sum_bit, maj_bit, xor_bit, res_bit;
    logic             ovf_bit, less_bit;
`ifdef SERIAL_ALU_FLAGS_EN
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
`endif

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
`ifdef SERIAL_ALU_FLAGS_EN
        zero_d   = zero_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
`endif
        // One full-adder slice; b is inverted for sub/slt with carry-in preset to 1.
        bit_a    = a_sh_q[0];
        bit_b    = b_sh_q[0] ^ op_q[1];
        sum_bit  = bit_a ^ bit_b ^ carry_q;
        maj_bit  = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);
        xor_bit  = a_sh_q[0] ^ b_sh_q[0];
        res_bit  = op_q[0] ? xor_bit : sum_bit;
        ovf_bit  = carry_q ^ maj_bit;
        less_bit = sum_bit ^ ovf_bit;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    op_d    = ALUControl;
                    cnt_d   = '0;
                    carry_d = ALUControl[1];
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                res_d   = {res_bit, res_q[WIDTH-1:1]};
                carry_d = maj_bit;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    if (op_q == 2'b11) begin
                        res_d = {{(WIDTH-1){1'b0}}, less_bit};
                    end
`ifdef SERIAL_ALU_FLAGS_EN
                    zero_d = (res_d == '0);
                    cout_d = maj_bit;
                    ovf_d  = (op_q == 2'b01) ? 1'b0 : ovf_bit;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
            zero_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
`ifdef SERIAL_ALU_FLAGS_EN
            zero_q  <= zero_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = res_q;
`ifdef SERIAL_ALU_FLAGS_EN
    assign zero      = zero_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_alu_engine.sv
// Scoreboard bench for serial_alu_engine: randomized and directed operations
// checked against an arithmetic reference model by an independent monitor.
module tb_serial_alu_engine;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         busy;
`ifdef SERIAL_ALU_FLAGS_EN
    logic         zero, carry_out, overflow;
`endif

    serial_alu_engine #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ALUControl(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
`ifdef SERIAL_ALU_FLAGS_EN
        , .zero(zero), .carry_out(carry_out), .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   last_acc = 0;
    bit   tb_busy = 0;
    bit   b2b = 0;
    bit   have_last = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] f);
        exp_t        e;
        logic [W:0]  s;
        logic [W-1:0] d;
        d = x - y;
        s = {1'b0, x} + {1'b0, y};
        case (f)
            2'b00: begin
                e.res = s[W-1:0];
                e.c   = s[W];
                e.v   = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
            end
            2'b10: begin
                e.res = d;
                e.c   = (x >= y);
                e.v   = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
            end
            2'b01: begin
                e.res = x ^ y;
                e.c   = s[W];
                e.v   = 1'b0;
            end
            default: begin
                e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
                e.c   = (x >= y);
                e.v   = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
            end
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // Monitor: tracks expected handshake state and scores every DONE cycle.
    always @(negedge clk) begin
        bit exp_ov;
        if (!rst_n) begin
            q.delete();
            tb_busy = 0;
        end else begin
            exp_ov = tb_busy && ((cyc - acc_cyc) >= W + 1);
            check("in_ready", in_ready, !tb_busy);
            check("busy", busy, tb_busy);
            check("out_valid", out_valid, exp_ov);
            if (exp_ov && q.size() > 0) begin
                check("result", result, q[0].res);
`ifdef SERIAL_ALU_FLAGS_EN
                check("zero", zero, q[0].z);
                check("carry_out", carry_out, q[0].c);
                check("overflow", overflow, q[0].v);
`endif
                if (out_ready) begin
                    void'(q.pop_front());
                    tb_busy = 0;
                end
            end else if (!tb_busy && in_valid) begin
                q.push_back(model(a, b, op));
                tb_busy = 1;
                if (b2b && have_last) check("b2b_spacing", cyc - last_acc, W + 2);
                last_acc  = cyc;
                have_last = b2b;
                acc_cyc   = cyc;
            end
        end
    end

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic [1:0] top);
        bit got = 0;
        a = ta; b = tb_b; op = top; in_valid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
        end
        if (!got) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_out();
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            got = out_valid;
        end
        if (!got) check("done_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic [1:0] top, input int dly);
        issue(ta, tb_b, top);
        in_valid = 1'b0;
        wait_out();
        repeat (dly) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(W-1){1'b0}}};
            3: return {1'b0, {(W-1){1'b1}}};
            default: return $urandom();
        endcase
    endfunction

    initial begin
        bit got;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);

        run_op(32'd5, 32'd7, 2'b00, 0);
        run_op(32'd3, 32'd5, 2'b10, 1);
        run_op(32'hF0F0_00FF, 32'h0FF0_FF0F, 2'b01, 0);
        run_op(32'hFFFF_FFFF, 32'd1, 2'b11, 2);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 2'b11, 0);

        // Backpressure with a competing request while DONE.
        out_ready = 1'b0;
        issue(32'h1234_5678, 32'h0F0F_0F0F, 2'b00);
        in_valid = 1'b0;
        wait_out();
        in_valid = 1'b1; a = $urandom(); b = $urandom(); op = 2'b10;
        repeat (10) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after_xfer", in_ready, 1);

        // Reset on the edge that would process bit 15.
        issue(32'hDEAD_BEEF, 32'h1111_1111, 2'b00);
        in_valid = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_out_valid", out_valid, 0);
        check("abort_result", result, 0);
        check("abort_in_ready", in_ready, 1);
        run_op(32'd1, 32'd1, 2'b00, 0);

        for (int k = 0; k < 16; k++) begin
            run_op(pick(), pick(), 2'($urandom_range(0, 3)), $urandom_range(0, 3));
        end

        // Back-to-back: request and response handshakes held high.
        b2b = 1; out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = $urandom(); b = $urandom(); op = 2'($urandom_range(0, 3));
            got = 0;
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk);
                got = in_ready;
            end
            if (!got) check("b2b_accept_timeout", 0, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            got = !tb_busy;
        end
        if (!got) check("b2b_drain_timeout", 0, 1);
        out_ready = 1'b0; b2b = 0;
        repeat (3) @(posedge clk);
        check("queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_alu_engine.md
# serial_alu_engine

Bit-serial ALU engine for the area-reduced execute option of the pipelined RISC-V core. It accepts two WIDTH-bit operands and a 2-bit ALU control code over a valid/ready handshake. It computes the result by iterating one full-adder/xor bit slice LSB-first, one bit per clock, and returns the result over a second valid/ready handshake. It replaces the parallel ripple ALU where throughput can be traded for area: one operation per WIDTH+2 cycles.

## Interface
- WIDTH, 32: operand/result width in bits (≥ 2).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low (sampled on clk rising edge).
- in_valid  input  1  operand request valid.
- in_ready  output  1  engine can accept an operation (high only in IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ALUControl  input  2  op code: 00 add, 10 sub, 01 xor, 11 slt (signed set-less-than).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  operation result, stable while out_valid high.
- busy  output  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - latch a, b, ALUControl into shift registers;
  - clear bit counter;
  - load carry register with ALUControl[1] (carry-in 1 for sub/slt);
  - go to RUN.
- RUN: each cycle processes bit k (k = counter, 0..WIDTH-1) from the LSB of the shift registers.
  - sum = a_k ^ (b_k ^ ALUControl[1]) ^ carry; carry ← majority of those three terms.
  - xor bit = a_k ^ b_k.
  - Result bit (sum for ALUControl[0]=0, xor bit for ALUControl[0]=1) shifts into the result register from the MSB side.
  - Operand registers shift right.
  - At k = WIDTH-1: capture carry-into-MSB and carry-out. overflow = cin_msb ^ cout; less = sum_msb ^ overflow. Go to DONE.
- Final result for slt: {WIDTH-1 zeros, less}, replacing the shifted bits. Other ops use the shifted register directly; arithmetic wraps modulo 2^WIDTH.
- DONE: out_valid=1, result held. On out_ready, go to IDLE. No new operation is accepted in DONE (no overlap).
- Inputs a, b, ALUControl are ignored outside the accept cycle.
- Reset: rst_n low at any clock edge, including mid-RUN or DONE, aborts the operation silently.
  - State → IDLE; counter, carry, result, shift registers cleared to 0.
  - Reset values: in_ready=1, out_valid=0, busy=0, result=0.

## Timing
- Accept at edge E0. RUN occupies edges E1..E_WIDTH. out_valid rises after E_WIDTH and is visible during the cycle following it: latency WIDTH+1 cycles from accept to out_valid.
- Output transfer at the first edge with out_valid&out_ready. in_ready rises in the next cycle; earliest next accept is one edge later.
- Minimum initiation interval: WIDTH+2 cycles (WIDTH=32 → 34).
- out_ready held low stalls indefinitely in DONE with result unchanged.
- in_ready is a registered state decode with no combinational path from in_valid or out_ready.

## Configuration
- SERIAL_ALU_FLAGS_EN defined:
  - Adds outputs zero (result==0), carry_out (final carry), overflow (signed overflow for add/sub/slt, 0 for xor). Each is 1 bit.
  - Flags are valid and held with out_valid and reset to 0.
- Not defined: those ports and their registers are absent; all other behaviour is identical.

## Test plan
- Reset, then add a=5, b=7 → out_valid exactly 33 cycles after accept (WIDTH=32), result=12; in_ready low throughout.
- sub a=3, b=5 → result=0xFFFFFFFE. With flags: carry_out=0, overflow=0, zero=0.
- xor a=0xF0F0_00FF, b=0x0FF0_FF0F → 0xFF00_FFF0. slt a=0xFFFFFFFF, b=1 → 1. slt a=0x7FFFFFFF, b=0x80000000 → 0 (overflow path; flags overflow=1).
- Backpressure: hold out_ready=0 for 10 cycles in DONE → result/out_valid stable, in_valid ignored. Release → transfer, IDLE next cycle.
- Reset mid-op: assert rst_n=0 at RUN bit 15 for one edge → out_valid=0, result=0, in_ready=1 next cycle. A new add 1+1 then completes with result=2.
- Back-to-back: in_valid held high, out_ready held high, 3 ops → accepts spaced exactly 34 cycles apart, results in order.
